// File: rtl/dht11_emulador.sv
// ---------------------------------------------------------------------------
// dht11_emulador
// Sensor-side emulation of the DHT11 single-wire protocol. Waits for the host
// start pulse (a long low on the bus), then answers with the response
// preamble and a 40-bit frame: umid_int, umid_dec, temp_int, temp_dec and a
// checksum. Open-drain: the bus arrives as a sampled level (dht_in) and this
// block only asks for the bus to be pulled low (dht_oe); the inout is built at
// the top level.
//
// Ports
//   clock             in   system clock
//   reset             in   asynchronous, active-low reset
//   habilita          in   1 = answer the bus, 0 = idle with the bus released
//   dht_in            in   sampled bus level (asynchronous, pulled up)
//   dht_oe            out  1 = pull bus low, 0 = release
//   umidade_int/dec   in   humidity bytes
//   temperatura_int/dec in temperature bytes
//   corrompe_checksum in   1 = transmitted checksum XOR 8'h01
//   ocupado           out  1 outside IDLE and HOST_LOW
//   pronto            out  one-cycle pulse at the end of a complete frame
//   db_estado         out  current state code
// ---------------------------------------------------------------------------
module dht11_emulador #(
  parameter int unsigned CICLOS_US      = 50,
  parameter int unsigned T_START_MIN_US = 18000,
  parameter int unsigned T_RESP_WAIT_US = 30,
  parameter int unsigned T_RESP_LOW_US  = 80,
  parameter int unsigned T_RESP_HIGH_US = 80,
  parameter int unsigned T_BIT_LOW_US   = 50,
  parameter int unsigned T_BIT0_HIGH_US = 27,
  parameter int unsigned T_BIT1_HIGH_US = 70
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       dht_in,
  output logic       dht_oe,
  input  logic [7:0] umidade_int,
  input  logic [7:0] umidade_dec,
  input  logic [7:0] temperatura_int,
  input  logic [7:0] temperatura_dec,
  input  logic       corrompe_checksum,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  // Phase lengths in clock cycles.
  localparam logic [23:0] L_START     = 24'(T_START_MIN_US * CICLOS_US);
  localparam logic [23:0] L_RESP_WAIT = 24'(T_RESP_WAIT_US * CICLOS_US);
  localparam logic [23:0] L_RESP_LOW  = 24'(T_RESP_LOW_US  * CICLOS_US);
  localparam logic [23:0] L_RESP_HIGH = 24'(T_RESP_HIGH_US * CICLOS_US);
  localparam logic [23:0] L_BIT_LOW   = 24'(T_BIT_LOW_US   * CICLOS_US);
  localparam logic [23:0] L_BIT0_HIGH = 24'(T_BIT0_HIGH_US * CICLOS_US);
  localparam logic [23:0] L_BIT1_HIGH = 24'(T_BIT1_HIGH_US * CICLOS_US);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    HOST_LOW  = 4'd1,
    RESP_WAIT = 4'd2,
    RESP_LOW  = 4'd3,
    RESP_HIGH = 4'd4,
    BIT_LOW   = 4'd5,
    BIT_HIGH  = 4'd6,
    FIM_LOW   = 4'd7,
    FIM       = 4'd8
  } estado_t;

  // Frame checksum: low byte of the 4-byte sum, optionally corrupted.
  function automatic logic [7:0] soma_verif(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d,
                                            input logic corrompe);
    logic [9:0] soma;
    soma = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return soma[7:0] ^ {7'b0000000, corrompe};
  endfunction

  // States in which the emulator pulls the bus low.
  function automatic logic oe_de(input estado_t s);
    logic oe;
    case (s)
      RESP_LOW, BIT_LOW, FIM_LOW: oe = 1'b1;
      default:                    oe = 1'b0;
    endcase
    return oe;
  endfunction

  logic        sinc1_q, sinc2_q;
  estado_t     estado_q, estado_d;
  logic [23:0] cont_q, cont_d;
  logic [39:0] quadro_q, quadro_d;
  logic [5:0]  nbits_q, nbits_d;
  logic        dht_oe_q, ocupado_q, pronto_q;
  logic [3:0]  db_estado_q;

  logic        bus_s;
  logic [23:0] limite_s;
  logic [23:0] cont_inc_s;
  logic        fim_fase_s;

  // Two-stage synchronizer for the asynchronous bus level; idles high like the pulled-up bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1_q <= 1'b1;
      sinc2_q <= 1'b1;
    end else begin
      sinc1_q <= dht_in;
      sinc2_q <= sinc1_q;
    end
  end

  assign bus_s = sinc2_q;

  // Length of the current timed phase; bit-high length follows the bit being sent.
  always_comb begin
    limite_s = 24'd0;
    case (estado_q)
      RESP_WAIT: limite_s = L_RESP_WAIT;
      RESP_LOW:  limite_s = L_RESP_LOW;
      RESP_HIGH: limite_s = L_RESP_HIGH;
      BIT_LOW:   limite_s = L_BIT_LOW;
      BIT_HIGH:  limite_s = quadro_q[39] ? L_BIT1_HIGH : L_BIT0_HIGH;
      FIM_LOW:   limite_s = L_BIT_LOW;
      default:   limite_s = 24'd0;
    endcase
  end

  // Saturating increment and terminal-count detect for the phase counter.
  always_comb begin
    cont_inc_s = (cont_q == 24'hFF_FFFF) ? cont_q : (cont_q + 24'd1);
    fim_fase_s = (cont_q == (limite_s - 24'd1));
  end

  // Next-state logic: enable drop wins over everything and discards the frame.
  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    quadro_d = quadro_q;
    nbits_d  = nbits_q;
    if (!habilita) begin
      estado_d = IDLE;
      cont_d   = 24'd0;
      nbits_d  = 6'd0;
    end else begin
      case (estado_q)
        IDLE: begin
          cont_d = 24'd0;
          if (!bus_s) begin
            estado_d = HOST_LOW;
          end else begin
            estado_d = IDLE;
          end
        end
        HOST_LOW: begin
          if (bus_s) begin
            cont_d = 24'd0;
            if (cont_q >= L_START) begin
              // Data is frozen here; later input changes do not reach the frame.
              quadro_d = {umidade_int, umidade_dec, temperatura_int, temperatura_dec,
                          soma_verif(umidade_int, umidade_dec, temperatura_int,
                                     temperatura_dec, corrompe_checksum)};
              nbits_d  = 6'd0;
              estado_d = RESP_WAIT;
            end else begin
              estado_d = IDLE;
            end
          end else begin
            cont_d = cont_inc_s;
          end
        end
        RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, FIM_LOW: begin
          if (fim_fase_s) begin
            cont_d = 24'd0;
            case (estado_q)
              RESP_WAIT: estado_d = RESP_LOW;
              RESP_LOW:  estado_d = RESP_HIGH;
              RESP_HIGH: estado_d = BIT_LOW;
              BIT_LOW:   estado_d = BIT_HIGH;
              FIM_LOW:   estado_d = FIM;
              default:   estado_d = IDLE;
            endcase
          end else begin
            cont_d = cont_inc_s;
          end
        end
        BIT_HIGH: begin
          if (fim_fase_s) begin
            cont_d   = 24'd0;
            quadro_d = {quadro_q[38:0], 1'b0};
            nbits_d  = nbits_q + 6'd1;
            if (nbits_q == 6'd39) begin
              estado_d = FIM_LOW;
            end else begin
              estado_d = BIT_LOW;
            end
          end else begin
            cont_d = cont_inc_s;
          end
        end
        FIM: begin
          // A bus still low here is picked up by IDLE as a fresh start, counting from zero.
          cont_d   = 24'd0;
          estado_d = IDLE;
        end
        default: begin
          cont_d   = 24'd0;
          estado_d = IDLE;
        end
      endcase
    end
  end

  // State, counter and frame registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= IDLE;
      cont_q   <= 24'd0;
      quadro_q <= 40'd0;
      nbits_q  <= 6'd0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      quadro_q <= quadro_d;
      nbits_q  <= nbits_d;
    end
  end

  // Outputs registered from the next state so they line up with estado_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dht_oe_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      pronto_q    <= 1'b0;
      db_estado_q <= 4'd0;
    end else begin
      dht_oe_q    <= oe_de(estado_d);
      ocupado_q   <= (estado_d != IDLE) && (estado_d != HOST_LOW);
      pronto_q    <= (estado_d == FIM);
      db_estado_q <= estado_d;
    end
  end

  assign dht_oe    = dht_oe_q;
  assign ocupado   = ocupado_q;
  assign pronto    = pronto_q;
  assign db_estado = db_estado_q;

endmodule
